// File: rtl/arp_pkg.sv
// Shared ARP constants, opcode/state types and the byte-map helper used by
// every lane of the serialiser.
package arp_pkg;

  localparam logic [15:0] ARP_HW_TYPE     = 16'h0001;
  localparam logic [15:0] ARP_PROT_TYPE   = 16'h0800;
  localparam logic [7:0]  ARP_HW_LEN      = 8'h06;
  localparam logic [7:0]  ARP_PROT_LEN    = 8'h04;
  localparam logic [15:0] ARP_OP_REQUEST  = 16'h0001;
  localparam logic [15:0] ARP_OP_REPLY    = 16'h0002;
  localparam int          ARP_LEN         = 28;
  localparam int          ETH_MIN_PAYLOAD = 46;

  typedef enum logic {
    ARP_REPLY   = 1'b0,
    ARP_REQUEST = 1'b1
  } arp_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } arp_state_t;

  // Byte at position idx of the ARP payload; fields are big-endian and any
  // index past the ARP body (padding) is zero. Requests carry an all-zero THA.
  function automatic logic [7:0] arp_byte(input logic [7:0]  idx,
                                          input arp_op_t     op,
                                          input logic [47:0] sha,
                                          input logic [31:0] spa,
                                          input logic [47:0] tha,
                                          input logic [31:0] tpa);
    logic [47:0] tha_eff;
    logic [15:0] opcode;
    logic [7:0]  b;
    tha_eff = (op == ARP_REQUEST) ? 48'h0 : tha;
    opcode  = (op == ARP_REQUEST) ? ARP_OP_REQUEST : ARP_OP_REPLY;
    b       = 8'h00;
    case (idx)
      8'd0:  b = ARP_HW_TYPE[15:8];
      8'd1:  b = ARP_HW_TYPE[7:0];
      8'd2:  b = ARP_PROT_TYPE[15:8];
      8'd3:  b = ARP_PROT_TYPE[7:0];
      8'd4:  b = ARP_HW_LEN;
      8'd5:  b = ARP_PROT_LEN;
      8'd6:  b = opcode[15:8];
      8'd7:  b = opcode[7:0];
      8'd8:  b = sha[47:40];
      8'd9:  b = sha[39:32];
      8'd10: b = sha[31:24];
      8'd11: b = sha[23:16];
      8'd12: b = sha[15:8];
      8'd13: b = sha[7:0];
      8'd14: b = spa[31:24];
      8'd15: b = spa[23:16];
      8'd16: b = spa[15:8];
      8'd17: b = spa[7:0];
      8'd18: b = tha_eff[47:40];
      8'd19: b = tha_eff[39:32];
      8'd20: b = tha_eff[31:24];
      8'd21: b = tha_eff[23:16];
      8'd22: b = tha_eff[15:8];
      8'd23: b = tha_eff[7:0];
      8'd24: b = tpa[31:24];
      8'd25: b = tpa[23:16];
      8'd26: b = tpa[15:8];
      8'd27: b = tpa[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/arp_frame_encoder_if.sv
// Output beat stream of the ARP serialiser.
// Handshake: a beat transfers on a rising clk edge where out_valid && out_ready;
// once out_valid is high, out_data/out_keep/out_last stay stable until that
// transfer, and out_ready may change freely without affecting valid.
interface arp_frame_encoder_if #(parameter int DW_BYTES = 1);
  logic                  out_valid;
  logic                  out_ready;
  logic [8*DW_BYTES-1:0] out_data;
  logic [DW_BYTES-1:0]   out_keep;
  logic                  out_last;

  modport master (output out_valid, out_data, out_keep, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_keep, out_last, output out_ready);
endinterface

// File: rtl/arp_lane_mux.sv
// Combinational beat builder: one arp_byte per lane, with lanes past the
// payload length masked to keep=0/data=0.
module arp_lane_mux
  import arp_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR = 48'h0,
  parameter logic [31:0] IP_ADDR  = 32'h0,
  parameter int          DW_BYTES = 1,
  parameter int          PKT_LEN  = ARP_LEN,
  parameter int          BW       = 5
) (
  input  logic [BW-1:0]          beat,
  input  arp_op_t                op,
  input  logic [47:0]            tha,
  input  logic [31:0]            tpa,
  output logic [8*DW_BYTES-1:0]  data,
  output logic [DW_BYTES-1:0]    keep
);

  int idx;

  // Lane l of beat k carries payload byte k*DW_BYTES+l.
  always_comb begin
    data = '0;
    keep = '0;
    idx  = 0;
    for (int lane = 0; lane < DW_BYTES; lane++) begin
      idx = int'(beat) * DW_BYTES + lane;
      if (idx < PKT_LEN) begin
        keep[lane]         = 1'b1;
        data[8*lane +: 8]  = arp_byte(idx[7:0], op, MAC_ADDR, IP_ADDR, tha, tpa);
      end
    end
  end

endmodule

// File: rtl/arp_frame_encoder.sv
// ARP packet serialiser: on start, emits an ARP request/reply (optionally
// padded to the Ethernet minimum payload) as DW_BYTES-wide beats.
module arp_frame_encoder
  import arp_pkg::*;
#(
  parameter logic [47:0] MAC_ADDR   = 48'h0,
  parameter logic [31:0] IP_ADDR    = 32'h0,
  parameter int          DW_BYTES   = 1,
  parameter int          PAD_TO_MIN = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                op,
  input  logic [47:0]         tha,
  input  logic [31:0]         tpa,
  output logic                busy,
  arp_frame_encoder_if.master tx,
  output arp_state_t          dbg_state
);

  localparam int L  = (PAD_TO_MIN != 0) ? ETH_MIN_PAYLOAD : ARP_LEN;
  localparam int N  = (L + DW_BYTES - 1) / DW_BYTES;
  localparam int BW = $clog2(N + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);

  if (!(DW_BYTES == 1 || DW_BYTES == 2 || DW_BYTES == 4)) begin : g_bad_dw
    $error("arp_frame_encoder: DW_BYTES must be 1, 2 or 4");
  end

  arp_state_t            state, state_d;
  logic [BW-1:0]         beat, beat_d, mux_beat;
  arp_op_t               op_q, mux_op;
  logic [47:0]           tha_q, mux_tha;
  logic [31:0]           tpa_q, mux_tpa;
  logic [8*DW_BYTES-1:0] data_q, mux_data;
  logic [DW_BYTES-1:0]   keep_q, mux_keep;
  logic                  last_q, valid_q;
  logic                  latch, load, clear;

  // While idle the mux looks at the live inputs so beat 0 is ready on accept;
  // while sending it looks at the latched request and the following beat.
  assign mux_beat = (state == ST_IDLE) ? '0 : beat + BW'(1);
  assign mux_op   = (state == ST_IDLE) ? arp_op_t'(op) : op_q;
  assign mux_tha  = (state == ST_IDLE) ? tha : tha_q;
  assign mux_tpa  = (state == ST_IDLE) ? tpa : tpa_q;

  arp_lane_mux #(
    .MAC_ADDR (MAC_ADDR),
    .IP_ADDR  (IP_ADDR),
    .DW_BYTES (DW_BYTES),
    .PKT_LEN  (L),
    .BW       (BW)
  ) u_lane_mux (
    .beat (mux_beat),
    .op   (mux_op),
    .tha  (mux_tha),
    .tpa  (mux_tpa),
    .data (mux_data),
    .keep (mux_keep)
  );

  // Next-state: accept start when idle, advance on each handshake, finish
  // after the last beat transfers.
  always_comb begin
    state_d = state;
    beat_d  = beat;
    latch   = 1'b0;
    load    = 1'b0;
    clear   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SEND;
          beat_d  = '0;
          latch   = 1'b1;
          load    = 1'b1;
        end
      end
      ST_SEND: begin
        if (valid_q && tx.out_ready) begin
          if (beat == LAST_BEAT) begin
            state_d = ST_IDLE;
            beat_d  = '0;
            clear   = 1'b1;
          end else begin
            beat_d = mux_beat;
            load   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        beat_d  = '0;
        clear   = 1'b1;
      end
    endcase
  end

  // State, request latch and registered output beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      beat    <= '0;
      op_q    <= ARP_REPLY;
      tha_q   <= '0;
      tpa_q   <= '0;
      data_q  <= '0;
      keep_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state <= state_d;
      beat  <= beat_d;
      if (latch) begin
        op_q  <= arp_op_t'(op);
        tha_q <= tha;
        tpa_q <= tpa;
      end
      if (load) begin
        data_q  <= mux_data;
        keep_q  <= mux_keep;
        last_q  <= (mux_beat == LAST_BEAT);
        valid_q <= 1'b1;
      end else if (clear) begin
        data_q  <= '0;
        keep_q  <= '0;
        last_q  <= 1'b0;
        valid_q <= 1'b0;
      end
    end
  end

  assign busy         = (state == ST_SEND);
  assign dbg_state    = state;
  assign tx.out_valid = valid_q;
  assign tx.out_data  = data_q;
  assign tx.out_keep  = keep_q;
  assign tx.out_last  = last_q;

endmodule

// File: tb/tb_arp_frame_encoder.sv
// Bench for arp_frame_encoder: three configurations (1B/no pad, 4B/pad,
// 2B/no pad) driven by directed packets; a per-instance expected-beat queue
// is filled at stimulus time and drained by negedge monitors.
module tb_arp_frame_encoder;
  import arp_pkg::*;

  localparam logic [47:0] MAC = 48'h020000000001;
  localparam logic [31:0] IP  = 32'hC0A8010A;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  start_v = 3'b000;
  logic        op = 1'b0;
  logic [47:0] tha = 48'h0;
  logic [31:0] tpa = 32'h0;
  logic        busy0, busy1, busy2;
  arp_state_t  dbg0, dbg1, dbg2;

  int n_checks = 0;
  int n_fail   = 0;

  arp_frame_encoder_if #(.DW_BYTES(1)) if0 ();
  arp_frame_encoder_if #(.DW_BYTES(4)) if1 ();
  arp_frame_encoder_if #(.DW_BYTES(2)) if2 ();

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  arp_frame_encoder #(.MAC_ADDR(MAC), .IP_ADDR(IP), .DW_BYTES(1), .PAD_TO_MIN(0)) u0 (
    .clk(clk), .rst(rst), .start(start_v[0]), .op(op), .tha(tha), .tpa(tpa),
    .busy(busy0), .tx(if0.master), .dbg_state(dbg0));
  arp_frame_encoder #(.MAC_ADDR(MAC), .IP_ADDR(IP), .DW_BYTES(4), .PAD_TO_MIN(1)) u1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .op(op), .tha(tha), .tpa(tpa),
    .busy(busy1), .tx(if1.master), .dbg_state(dbg1));
  arp_frame_encoder #(.MAC_ADDR(MAC), .IP_ADDR(IP), .DW_BYTES(2), .PAD_TO_MIN(0)) u2 (
    .clk(clk), .rst(rst), .start(start_v[2]), .op(op), .tha(tha), .tpa(tpa),
    .busy(busy2), .tx(if2.master), .dbg_state(dbg2));

  // Reference reply byte stream for MAC/IP above, tha=AABBCCDDEEFF, tpa=C0A80102.
  logic [7:0] ref_reply [28] = '{
    8'h00, 8'h01, 8'h08, 8'h00, 8'h06, 8'h04, 8'h00, 8'h02,
    8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h01, 8'hC0, 8'hA8,
    8'h01, 8'h0A, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE, 8'hFF,
    8'hC0, 8'hA8, 8'h01, 8'h02};

  // scoreboard: {last, keep[3:0], data[31:0]}
  logic [36:0] exp_q0[$];
  logic [36:0] exp_q1[$];
  logic [36:0] exp_q2[$];

  int          hs_cnt    [3] = '{0, 0, 0};
  logic        prev_stall[3] = '{1'b0, 1'b0, 1'b0};
  logic        prev_hlast[3] = '{1'b0, 1'b0, 1'b0};
  logic [36:0] prev_beat [3] = '{37'h0, 37'h0, 37'h0};

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic logic [7:0] exp_byte(input int i, input bit is_req);
    if (i >= 28) return 8'h00;
    if (is_req && i == 7) return 8'h01;
    if (is_req && i >= 18 && i <= 23) return 8'h00;
    return ref_reply[i];
  endfunction

  function automatic int qsize(input int inst);
    case (inst)
      0: return exp_q0.size();
      1: return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  function automatic logic inst_busy(input int inst);
    case (inst)
      0: return busy0;
      1: return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic push_packet(input int inst, input bit is_req, input int dw, input int len);
    int n = (len + dw - 1) / dw;
    for (int k = 0; k < n; k++) begin
      logic [31:0] d;
      logic [3:0]  kp;
      logic [36:0] ent;
      d  = '0;
      kp = '0;
      for (int lane = 0; lane < dw; lane++) begin
        if (k * dw + lane < len) begin
          kp[lane]       = 1'b1;
          d[8*lane +: 8] = exp_byte(k * dw + lane, is_req);
        end
      end
      ent = {(k == n - 1), kp, d};
      case (inst)
        0: exp_q0.push_back(ent);
        1: exp_q1.push_back(ent);
        default: exp_q2.push_back(ent);
      endcase
    end
  endtask

  // monitor body shared by the three instances
  task automatic mon(input int i, input logic valid, input logic ready, input logic [31:0] data,
                     input logic [3:0] keep, input logic last, input logic busy);
    logic [36:0] cur, e;
    logic        empty;
    cur = {last, keep, data};
    if (rst) begin
      prev_stall[i] = 1'b0;
      prev_hlast[i] = 1'b0;
      return;
    end
    if (prev_hlast[i])
      chk($sformatf("u%0d_after_last {valid,busy,last,keep,data}", i),
          {valid, busy, cur}, 64'h0);
    if (prev_stall[i] && valid)
      chk($sformatf("u%0d_stall_hold", i), cur, prev_beat[i]);
    if (valid && ready) begin
      empty = 1'b0;
      e     = '0;
      case (i)
        0: if (exp_q0.size() == 0) empty = 1'b1; else e = exp_q0.pop_front();
        1: if (exp_q1.size() == 0) empty = 1'b1; else e = exp_q1.pop_front();
        default: if (exp_q2.size() == 0) empty = 1'b1; else e = exp_q2.pop_front();
      endcase
      if (empty) begin
        n_checks++;
        n_fail++;
        $display("FAIL u%0d_unexpected_beat: got 0x%0h expected no beat", i, cur);
      end else begin
        chk($sformatf("u%0d_beat%0d {last,keep,data}", i, hs_cnt[i]), cur, e);
      end
      hs_cnt[i]++;
    end
    prev_stall[i] = valid && !ready;
    prev_hlast[i] = valid && ready && last;
    prev_beat[i]  = cur;
  endtask

  always @(negedge clk) mon(0, if0.out_valid, if0.out_ready, {24'h0, if0.out_data},
                            {3'h0, if0.out_keep}, if0.out_last, busy0);
  always @(negedge clk) mon(1, if1.out_valid, if1.out_ready, if1.out_data,
                            if1.out_keep, if1.out_last, busy1);
  always @(negedge clk) mon(2, if2.out_valid, if2.out_ready, {16'h0, if2.out_data},
                            {2'h0, if2.out_keep}, if2.out_last, busy2);

  // driver: one-cycle start, then scramble tha/tpa to prove they were latched
  task automatic drive_start(input int inst, input logic o, input logic [47:0] h, input logic [31:0] p);
    @(posedge clk); #1;
    op = o; tha = h; tpa = p;
    start_v[inst] = 1'b1;
    @(posedge clk); #1;
    start_v[inst] = 1'b0;
    tha = 48'h123456789ABC;
    tpa = 32'hDEADBEEF;
    op  = ~o;
    @(negedge clk);
    chk($sformatf("u%0d_accept_latency {busy,valid}", inst),
        {inst_busy(inst), (inst == 0) ? if0.out_valid : (inst == 1) ? if1.out_valid : if2.out_valid},
        2'b11);
  endtask

  task automatic wait_idle(input int inst, input int budget);
    bit done = 1'b0;
    for (int c = 0; c < budget && !done; c++) begin
      @(negedge clk);
      if (qsize(inst) == 0 && !inst_busy(inst)) done = 1'b1;
    end
    chk($sformatf("u%0d_packet_done_in_budget", inst), done, 1'b1);
  endtask

  int base;

  initial begin
    if0.out_ready = 1'b1;
    if1.out_ready = 1'b1;
    if2.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset u0 {busy,valid,last,keep,data,state}",
        {busy0, if0.out_valid, if0.out_last, if0.out_keep, if0.out_data, dbg0}, 64'h0);
    chk("reset u1 {busy,valid,last,keep,data,state}",
        {busy1, if1.out_valid, if1.out_last, if1.out_keep, if1.out_data, dbg1}, 64'h0);
    chk("reset u2 {busy,valid,last,keep,data,state}",
        {busy2, if2.out_valid, if2.out_last, if2.out_keep, if2.out_data, dbg2}, 64'h0);

    // 1B reply, continuous ready
    base = hs_cnt[0];
    push_packet(0, 1'b0, 1, 28);
    drive_start(0, 1'b0, 48'hAABBCCDDEEFF, 32'hC0A80102);
    wait_idle(0, 100);
    chk("u0_reply_handshakes", hs_cnt[0] - base, 28);

    // 4B padded request; THA must come out zero
    base = hs_cnt[1];
    push_packet(1, 1'b1, 4, 46);
    drive_start(1, 1'b1, 48'hAABBCCDDEEFF, 32'hC0A80102);
    wait_idle(1, 100);
    chk("u1_request_handshakes", hs_cnt[1] - base, 12);

    // 2B reply with ready pattern 1,0,0 repeating
    base = hs_cnt[2];
    push_packet(2, 1'b0, 2, 28);
    drive_start(2, 1'b0, 48'hAABBCCDDEEFF, 32'hC0A80102);
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      if2.out_ready = (c % 3 == 0);
      @(negedge clk);
      if (qsize(2) == 0 && !busy2) break;
    end
    if2.out_ready = 1'b1;
    wait_idle(2, 10);
    chk("u2_stalled_handshakes", hs_cnt[2] - base, 14);

    // start while busy with different tha/tpa is ignored
    base = hs_cnt[0];
    push_packet(0, 1'b0, 1, 28);
    drive_start(0, 1'b0, 48'hAABBCCDDEEFF, 32'hC0A80102);
    repeat (3) @(posedge clk);
    #1;
    op = 1'b1; tha = 48'h111111111111; tpa = 32'h01020304;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    wait_idle(0, 100);
    repeat (10) @(negedge clk);
    chk("u0_ignored_start_handshakes", hs_cnt[0] - base, 28);
    chk("u0_idle_after_ignored_start {busy,valid}", {busy0, if0.out_valid}, 2'b00);

    // reset at beat 10, then a fresh packet
    base = hs_cnt[0];
    push_packet(0, 1'b0, 1, 28);
    drive_start(0, 1'b0, 48'hAABBCCDDEEFF, 32'hC0A80102);
    for (int c = 0; c < 50; c++) begin
      if (hs_cnt[0] - base >= 10) break;
      @(negedge clk);
    end
    chk("u0_reached_beat10", hs_cnt[0] - base, 10);
    @(posedge clk); #1;
    rst = 1'b1;
    exp_q0.delete();
    @(posedge clk); #1;
    chk("u0_abort {busy,valid,last,keep,data,state}",
        {busy0, if0.out_valid, if0.out_last, if0.out_keep, if0.out_data, dbg0}, 64'h0);
    rst = 1'b0;
    base = hs_cnt[0];
    push_packet(0, 1'b0, 1, 28);
    drive_start(0, 1'b0, 48'hAABBCCDDEEFF, 32'hC0A80102);
    wait_idle(0, 100);
    chk("u0_after_reset_handshakes", hs_cnt[0] - base, 28);

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", qsize(0) + qsize(1) + qsize(2), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/arp_frame_encoder.md
Name: arp_frame_encoder

Overview:
- Parametrised ARP packet serialiser. Generalises the byte-serial ARP reply encoder to configurable datapath width (1/2/4 bytes per beat), request or reply opcode, optional padding to the Ethernet minimum payload, and a ready/valid output with backpressure.
- Sits between the ARP responder/requester logic and the Ethernet TX framer. The framer prepends the MAC header and FCS.

Parameters:
- MAC_ADDR, 48'h0, local hardware address; emitted as SHA.
- IP_ADDR, 32'h0, local IPv4 address; emitted as SPA.
- DW_BYTES, 1, bytes per output beat; legal values 1, 2, 4; any other value is a static elaboration error.
- PAD_TO_MIN, 0, 1 = append 18 zero bytes so the payload is 46 bytes; 0 = 28-byte ARP payload only.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle request to emit a packet; sampled only when busy=0
- op  in  1  0 = reply (opcode 0x0002), 1 = request (opcode 0x0001)
- tha  in  48  target hardware address; latched on accepted start
- tpa  in  32  target protocol address; latched on accepted start
- busy  out  1  a packet is in progress
- out_valid  out  1  beat on out_data is valid
- out_ready  in  1  downstream accepts the beat
- out_data  out  8*DW_BYTES  beat data; lane 0 (bits 7:0) carries the earliest byte
- out_keep  out  DW_BYTES  per-lane byte-valid mask
- out_last  out  1  final beat of the packet

Behaviour:
- Reset values: busy=0, out_valid=0, out_data=0, out_keep=0, out_last=0. FSM=IDLE, beat counter=0.
- L = 28 if PAD_TO_MIN=0, else 46. N = ceil(L/DW_BYTES).
- Byte map, big-endian per field:
  - 0-1: 0x0001
  - 2-3: 0x0800
  - 4: 0x06
  - 5: 0x04
  - 6-7: opcode
  - 8-13: MAC_ADDR
  - 14-17: IP_ADDR
  - 18-23: THA
  - 24-27: TPA
  - 28..L-1: 0x00
- Request (op=1): the THA field is emitted as all zeros regardless of tha. TPA is always the latched tpa.
- FSM IDLE -> SEND:
  - On start && !busy, latch op/tha/tpa and load beat 0 into the output registers.
  - Next cycle: busy=1 and out_valid=1 with beat 0 (latency 1 cycle).
- In SEND, a handshake (out_valid && out_ready) advances to the next beat, registered. A beat may issue every cycle while out_ready=1.
- Stall: while out_valid && !out_ready, out_data, out_keep and out_last hold stable.
- Beat k carries bytes k*DW_BYTES .. k*DW_BYTES+DW_BYTES-1.
- Last beat (k=N-1):
  - out_last=1.
  - Lanes with byte index >= L have keep=0 and data=0.
  - All other beats have keep all-ones.
- After the last-beat handshake, the next cycle has out_valid=0, busy=0, out_last=0, out_keep=0, out_data=0, FSM=IDLE.
- start is accepted no earlier than the cycle in which busy reads 0.
- start while busy=1 is ignored; there is no queueing. tha/tpa changes after the accepted start have no effect on the packet in flight.
- rst mid-packet aborts immediately to the reset values. No out_last is emitted for the aborted packet.
- Beat counter width $clog2(N+1). It never exceeds N-1 in SEND.

Decomposition:
- Package arp_pkg holds:
  - constants ARP_HW_TYPE, ARP_PROT_TYPE, ARP_HW_LEN, ARP_PROT_LEN, ARP_OP_REQUEST, ARP_OP_REPLY, ARP_LEN=28, ETH_MIN_PAYLOAD=46;
  - typedef arp_op_t;
  - function arp_byte(idx, op, sha, spa, tha, tpa) returning the byte at an index.
- One sub-module, arp_lane_mux: combinational, DW_BYTES instances of arp_byte plus the keep/zero masking for a given beat index. Each lane computes idx = beat*DW_BYTES+lane.

Test Plan:
- DW_BYTES=1, PAD=0, MAC=02:00:00:00:00:01, IP=C0A8010A, op=0, tha=AA:BB:CC:DD:EE:FF, tpa=C0A80102, out_ready=1 -> 28 consecutive beats 00 01 08 00 06 04 00 02 02 00 00 00 00 01 C0 A8 01 0A AA BB CC DD EE FF C0 A8 01 02; out_last on beat 27 only; busy drops the next cycle.
- DW_BYTES=4, PAD=1, op=1 -> 12 beats:
  - beat 1 data 0x01000406 (lanes 06 04 00 01);
  - beats 4-5 THA = zeros;
  - beat 11 keep=4'b0011, data=0, out_last=1.
- DW_BYTES=2, PAD=0, out_ready toggling 1,0,0,1,... -> data held stable across stalls; exactly 14 handshakes; byte stream identical to the first scenario.
- start pulsed while busy with a different tpa -> ignored; current packet completes unchanged; no second packet emitted.
- rst asserted at beat 10 of 28 -> next cycle all outputs 0. A fresh start then emits a complete packet beginning with 00 01.
